// File: rtl/bus_codec_param.sv
`default_nettype none
// ============================================================================
// Module   : bus_codec_param
// Purpose  : Low-power bus encoder with a matching decoder. The encoder
//            registers one word per cycle onto an N+P line bus using one of
//            four codings: normal, segmented bus-invert, gray, or T0
//            (increment-hold). The decoder recovers the original word from
//            the registered bus one cycle later. A saturating counter
//            accumulates the number of line toggles on the encoded bus.
// Ports    : ck        in   clock, rising edge
//            rst       in   asynchronous reset, active low
//            A         in   N    word to encode, sampled every cycle
//            mode      in   2    0 normal, 1 bus-invert, 2 gray, 3 T0
//            cnt_clr   in   1    synchronous clear of trans_cnt (wins)
//            B         out  N+P  registered encoded bus (data + extra lines)
//            C         out  N    registered decoded word (A delayed 2 cycles)
//            C_vld     out  1    C holds a decoded word
//            trans_cnt out  CW   saturating cumulative toggle count on B
// Revision : 1.0  initial release
// ============================================================================
module bus_codec_param #(
  parameter int N      = 8,
  parameter int P      = 1,
  parameter int STRIDE = 1,
  parameter int CW     = 32
) (
  input  logic           ck,
  input  logic           rst,
  input  logic [N-1:0]   A,
  input  logic [1:0]     mode,
  input  logic           cnt_clr,
  output logic [N+P-1:0] B,
  output logic [N-1:0]   C,
  output logic           C_vld,
  output logic [CW-1:0]  trans_cnt
);

  localparam int         c_s         = N / P;
  localparam logic [1:0] c_mode_norm = 2'd0;
  localparam logic [1:0] c_mode_binv = 2'd1;
  localparam logic [1:0] c_mode_gray = 2'd2;
  localparam logic [1:0] c_mode_t0   = 2'd3;
  localparam logic [N-1:0] c_stride  = N'(STRIDE);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [N+P-1:0] r_b;      // encoded bus
  logic [1:0]     r_tag;    // mode that produced r_b, travels with it
  logic [N-1:0]   r_aprev;  // previous input word, for T0 detection
  logic           r_t0v;    // previous cycle was a T0 cycle
  logic [N-1:0]   r_c;      // decoded word
  logic           r_v1;     // first edge after reset seen
  logic           r_cvld;   // second edge after reset seen
  logic [CW-1:0]  r_cnt;    // toggle counter

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  function automatic logic [31:0] f_popcnt_seg(input logic [c_s-1:0] v);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < c_s; i++) begin
      n = n + {31'd0, v[i]};
    end
    return n;
  endfunction

  function automatic logic [31:0] f_popcnt_bus(input logic [N+P-1:0] v);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < N + P; i++) begin
      n = n + {31'd0, v[i]};
    end
    return n;
  endfunction

  // --------------------------------------------------------------------------
  // Encoder
  // --------------------------------------------------------------------------
  logic [P-1:0]   w_inv;
  logic [N-1:0]   w_bi_data;
  logic [N-1:0]   w_t0_exp;
  logic           w_inc;
  logic [P-1:0]   w_ext;
  logic [N-1:0]   w_data;
  logic [N+P-1:0] w_b_next;

  // Bus-invert compares against the data lines currently driven, whatever
  // mode produced them; a tie (hd == S/2) keeps the segment uninverted.
  generate
    for (genvar k = 0; k < P; k++) begin : g_enc_seg
      logic [c_s-1:0] w_aseg;
      logic [c_s-1:0] w_pseg;
      assign w_aseg   = A[k*c_s +: c_s];
      assign w_pseg   = r_b[k*c_s +: c_s];
      assign w_inv[k] = (f_popcnt_seg(w_aseg ^ w_pseg) > 32'(c_s / 2));
      assign w_bi_data[k*c_s +: c_s] = w_aseg ^ {c_s{w_inv[k]}};
    end
  endgenerate

  // T0 only signals an increment when the previous cycle was also T0, so the
  // decoder is guaranteed to hold the matching previous word in r_c.
  assign w_t0_exp = r_aprev + c_stride;
  assign w_inc    = r_t0v && (A == w_t0_exp);

  always_comb begin
    w_ext  = '0;
    w_data = A;
    case (mode)
      c_mode_norm: begin
        w_data = A;
      end
      c_mode_binv: begin
        w_data = w_bi_data;
        w_ext  = w_inv;
      end
      c_mode_gray: begin
        w_data = A ^ (A >> 1);
      end
      c_mode_t0: begin
        w_data   = w_inc ? r_b[N-1:0] : A;
        w_ext[0] = w_inc;
      end
      default: begin
        w_data = A;
      end
    endcase
  end

  assign w_b_next = {w_ext, w_data};

  // --------------------------------------------------------------------------
  // Decoder (operates on r_b / r_tag)
  // --------------------------------------------------------------------------
  logic [N-1:0] w_bi_dec;
  logic [N-1:0] w_gray_dec;
  logic [N-1:0] w_c_next;

  generate
    for (genvar k = 0; k < P; k++) begin : g_dec_seg
      assign w_bi_dec[k*c_s +: c_s] = r_b[k*c_s +: c_s] ^ {c_s{r_b[N+k]}};
    end
  endgenerate

  // Binary bit i is the XOR of gray bits i..N-1; shifting right brings
  // exactly those bits into the reduction without a ripple chain.
  always_comb begin
    w_gray_dec = '0;
    for (int i = 0; i < N; i++) begin
      w_gray_dec[i] = ^(r_b[N-1:0] >> i);
    end
  end

  always_comb begin
    w_c_next = r_b[N-1:0];
    case (r_tag)
      c_mode_binv: w_c_next = w_bi_dec;
      c_mode_gray: w_c_next = w_gray_dec;
      c_mode_t0:   w_c_next = r_b[N] ? (r_c + c_stride) : r_b[N-1:0];
      default:     w_c_next = r_b[N-1:0];
    endcase
  end

  // --------------------------------------------------------------------------
  // Toggle counter
  // --------------------------------------------------------------------------
  logic [31:0]   w_tog;
  logic [CW:0]   w_sum;
  logic [CW-1:0] w_cnt_next;

  assign w_tog      = f_popcnt_bus(w_b_next ^ r_b);
  assign w_sum      = {1'b0, r_cnt} + (CW+1)'(w_tog);
  assign w_cnt_next = w_sum[CW] ? {CW{1'b1}} : w_sum[CW-1:0];

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      r_b     <= '0;
      r_tag   <= c_mode_norm;
      r_aprev <= '0;
      r_t0v   <= 1'b0;
      r_c     <= '0;
      r_v1    <= 1'b0;
      r_cvld  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_b     <= w_b_next;
      r_tag   <= mode;
      r_aprev <= A;
      r_t0v   <= (mode == c_mode_t0);
      r_c     <= w_c_next;
      r_v1    <= 1'b1;
      r_cvld  <= r_v1;
      r_cnt   <= cnt_clr ? '0 : w_cnt_next;
    end
  end

  assign B         = r_b;
  assign C         = r_c;
  assign C_vld     = r_cvld;
  assign trans_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_bus_codec_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_codec_param
// Purpose  : Self-checking bench for bus_codec_param (N=8, P=1, STRIDE=1).
//            A second instance with CW=4 shares the stimulus to exercise
//            counter saturation.
// Revision : 1.0  initial release
// ============================================================================
module tb_bus_codec_param;

  logic       ck = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] A = 8'h00;
  logic [1:0] mode = 2'd0;
  logic       cnt_clr = 1'b0;

  logic [8:0]  B, B4;
  logic [7:0]  C, C4;
  logic        C_vld, C_vld4;
  logic [31:0] trans_cnt;
  logic [3:0]  cnt4;

  always #5 ck = ~ck;

  bus_codec_param #(.N(8), .P(1), .STRIDE(1), .CW(32)) dut (
    .ck(ck), .rst(rst), .A(A), .mode(mode), .cnt_clr(cnt_clr),
    .B(B), .C(C), .C_vld(C_vld), .trans_cnt(trans_cnt)
  );

  bus_codec_param #(.N(8), .P(1), .STRIDE(1), .CW(4)) dut4 (
    .ck(ck), .rst(rst), .A(A), .mode(mode), .cnt_clr(cnt_clr),
    .B(B4), .C(C4), .C_vld(C_vld4), .trans_cnt(cnt4)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: bus contents, history, and C as A delayed two edges.
  logic [8:0] m_b;
  logic [7:0] m_aprev;
  logic [7:0] m_ahist;
  logic [7:0] m_c;
  bit         m_t0v;
  longint     m_cnt;
  longint     m_cnt4;
  int         m_edges;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_b = '0; m_aprev = '0; m_ahist = '0; m_c = '0;
    m_t0v = 1'b0; m_cnt = 0; m_cnt4 = 0; m_edges = 0;
  endtask

  task automatic model_step(input logic [7:0] a, input logic [1:0] m, input logic clr);
    logic [8:0] nb;
    logic [7:0] nxt;
    int hd, tog;
    nxt = m_aprev + 8'd1;
    case (m)
      2'd0: nb = {1'b0, a};
      2'd1: begin
        hd = $countones(a ^ m_b[7:0]);
        nb = (hd > 4) ? {1'b1, ~a} : {1'b0, a};
      end
      2'd2: nb = {1'b0, a ^ (a >> 1)};
      default: nb = (m_t0v && a == nxt) ? {1'b1, m_b[7:0]} : {1'b0, a};
    endcase
    tog = $countones(nb ^ m_b);
    if (clr) begin
      m_cnt = 0; m_cnt4 = 0;
    end else begin
      m_cnt  = (m_cnt + tog > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_cnt + tog;
      m_cnt4 = (m_cnt4 + tog > 15) ? 15 : m_cnt4 + tog;
    end
    m_b = nb;
    m_c = m_ahist;
    m_ahist = a;
    m_aprev = a;
    m_t0v = (m == 2'd3);
    m_edges++;
  endtask

  task automatic check_all();
    chk("B", 64'(B), 64'(m_b));
    chk("C", 64'(C), 64'(m_c));
    chk("C_vld", 64'(C_vld), 64'(m_edges >= 2));
    chk("trans_cnt", 64'(trans_cnt), 64'(m_cnt));
    chk("trans_cnt_cw4", 64'(cnt4), 64'(m_cnt4));
  endtask

  task automatic cycle(input logic [7:0] a, input logic [1:0] m, input logic clr);
    A = a; mode = m; cnt_clr = clr;
    @(posedge ck);
    model_step(a, m, clr);
    #1;
    check_all();
  endtask

  // Reset asserted between edges: outputs must clear with no clock edge.
  task automatic mid_reset();
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge ck);
    rst = 1'b1;
  endtask

  initial begin
    model_reset();
    #1 rst = 1'b0;
    #1 check_all();
    @(negedge ck);
    rst = 1'b1;

    // normal mode
    cycle(8'h00, 2'd0, 1'b0);
    cycle(8'hFF, 2'd0, 1'b0);
    chk("norm_B", 64'(B), 64'h0FF);
    cycle(8'hFF, 2'd0, 1'b0);
    chk("norm_C", 64'(C), 64'hFF);
    chk("norm_vld", 64'(C_vld), 64'd1);

    // bus-invert including tie
    cycle(8'h00, 2'd0, 1'b0);
    cycle(8'h00, 2'd0, 1'b0);
    cycle(8'hFF, 2'd1, 1'b0);
    chk("binv_B1", 64'(B), 64'h100);
    cycle(8'h0F, 2'd1, 1'b0);
    chk("binv_tie", 64'(B), 64'h00F);

    // T0 including wrap
    cycle(8'h10, 2'd3, 1'b0);
    chk("t0_first", 64'(B), 64'h010);
    cycle(8'h11, 2'd3, 1'b0);
    cycle(8'h12, 2'd3, 1'b0);
    chk("t0_hold", 64'(B), 64'h110);
    cycle(8'hFF, 2'd3, 1'b0);
    cycle(8'h00, 2'd3, 1'b0);
    chk("t0_wrap", 64'(B[8]), 64'd1);

    // gray, then switch to T0
    cycle(8'h7F, 2'd2, 1'b0);
    chk("gray1", 64'(B), 64'h040);
    cycle(8'h80, 2'd2, 1'b0);
    chk("gray2", 64'(B), 64'h0C0);
    cycle(8'h81, 2'd3, 1'b0);
    chk("t0_after_gray", 64'(B), 64'h081);
    cycle(8'h82, 2'd0, 1'b0);
    cycle(8'h83, 2'd0, 1'b0);

    // counter saturation (CW=4) and clear-wins
    cycle(8'h00, 2'd0, 1'b1);
    cycle(8'hFF, 2'd0, 1'b0);
    cycle(8'h00, 2'd0, 1'b0);
    cycle(8'hFF, 2'd0, 1'b0);
    chk("sat_cw4", 64'(cnt4), 64'd15);
    cycle(8'h00, 2'd0, 1'b1);
    chk("clr_wins", 64'(trans_cnt), 64'd0);

    // reset mid-stream then T0 from a clean history
    cycle(8'h55, 2'd3, 1'b0);
    cycle(8'h56, 2'd3, 1'b0);
    mid_reset();
    cycle(8'h01, 2'd3, 1'b0);
    chk("post_rst_t0", 64'(B), 64'h001);

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      logic [7:0] a;
      logic [1:0] m;
      logic       clr;
      if ($urandom_range(0, 99) < 2) mid_reset();
      m   = 2'($urandom_range(0, 3));
      a   = ($urandom_range(0, 2) == 0) ? m_aprev + 8'd1 : 8'($urandom);
      clr = ($urandom_range(0, 40) == 0);
      cycle(a, m, clr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bus_codec_param.md
BUS_CODEC_PARAM -- requirements
Module: bus_codec_param

Interface
REQ-001 Parameter N, default 8: data width; N >= 2.
REQ-002 Parameter P, default 1: bus-invert segment count; N mod P = 0; segment width S = N/P.
REQ-003 Parameter STRIDE, default 1: T0 increment, modulo 2^N.
REQ-004 Parameter CW, default 32: transition-counter width.
REQ-005 ck  input  1  clock; all state updates on the rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 A  input  N  data/address word to encode, sampled every cycle.
REQ-008 mode  input  2  coding mode: 0 normal, 1 bus-invert, 2 gray, 3 T0; sampled every cycle.
REQ-009 cnt_clr  input  1  synchronous clear of trans_cnt.
REQ-010 B  output  N+P  registered encoded bus; B[N-1:0] data lines, B[N+P-1:N] extra lines.
REQ-011 C  output  N  registered decoded word.
REQ-012 C_vld  output  1  C holds a decoded word.
REQ-013 trans_cnt  output  CW  cumulative toggle count on B.

Function
REQ-014 Encoder shall register one word per cycle: B(t+1) = enc(A(t), mode(t)); latency A->B is 1 cycle.
REQ-015 Decoder shall register one word per cycle from B and an internal mode tag registered alongside B; latency A->C is 2 cycles, C = A in every mode.
REQ-016 Mode 0: data = A; extra lines = 0.
REQ-017 Mode 1: per segment k, hd = popcount(A_seg ^ previous B data segment); invert iff hd > S/2 (floor); data segment = A_seg ^ {S{inv}}, B[N+k] = inv.
REQ-018 Mode 1 tie (hd = S/2) shall not invert; comparison uses previously driven data lines regardless of previous mode.
REQ-019 Mode 2: data = A ^ (A >> 1); extra lines = 0.
REQ-020 Mode 3: if T0 history valid and A == A_prev + STRIDE (mod 2^N), data lines held, B[N] = 1 (INC); otherwise data = A, B[N] = 0; B[N+P-1:N+1] = 0.
REQ-021 A_prev shall be updated with A every cycle in every mode; T0 history valid only if the previous cycle was mode 3 and not reset.
REQ-022 Mode change takes effect in the sampling cycle; the first mode-3 cycle after any other mode or reset shall drive INC = 0.
REQ-023 Decoder: mode 0 C = data; mode 1 C_seg = data_seg ^ {S{B[N+k]}}; mode 2 binary from gray; mode 3 INC=1 gives C = C_prev + STRIDE mod 2^N, INC=0 gives C = data.
REQ-024 trans_cnt shall add popcount(B_next ^ B) on every B update, all N+P lines, saturating at 2^CW-1.
REQ-025 cnt_clr = 1 shall load trans_cnt = 0, discarding that cycle's increment (clear wins).
REQ-026 C_vld shall be 0 until two rising edges after reset release, then 1 continuously.

Reset
REQ-027 rst low shall immediately force B = 0, C = 0, C_vld = 0, trans_cnt = 0, A_prev = 0, mode tag = 0, T0 history invalid.
REQ-028 Reset asserted mid-stream shall discard all in-flight words; first post-reset word is encoded against B = 0.
REQ-029 Reset release shall not itself count transitions.

Verification
REQ-030 Normal (N=8,P=1): A=0x00 then 0xFF -> B=0x000 then 0x0FF, trans_cnt +8, C=0xFF two cycles after A, C_vld high.
REQ-031 Bus-invert: B=0x000, A=0xFF -> B=0x100, +1; then A=0x0F (hd 4, tie) -> B=0x00F, +5; C=0xFF, 0x0F.
REQ-032 T0: A=0x10,0x11,0x12 -> B=0x010,0x110,0x110, increments +1 then +0; A=0xFF,0x00 -> INC=1 on wrap; C tracks A.
REQ-033 Gray and mode switch: mode 2 A=0x7F,0x80 -> B=0x040,0x0C0; switch to mode 3 with A=0x81 -> B[8]=0; C=0x7F,0x80,0x81.
REQ-034 Counter: CW=4, drive toggles past 15 -> trans_cnt holds 15; cnt_clr with an 8-bit toggle same cycle -> trans_cnt = 0.
REQ-035 Reset mid-stream: rst low between edges -> B, C, trans_cnt = 0 and C_vld = 0 without a clock edge; after release, mode 3 with A=0x01 -> B=0x001, INC=0.
